// File: rtl/core_boot_sequencer_if.sv
// Shared payload types and the image / data_mem / net-packet bus of the boot sequencer.
// The sequencer drives the master side; image ROM, data_mem and core sit on the slave side.
package core_boot_sequencer_pkg;

    localparam int unsigned IDX_W  = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMG_W  = 40;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned ID_W   = 10;

    typedef enum logic [2:0] {
        NET_OP_NULL  = 3'd0,
        NET_OP_INSTR = 3'd1,
        NET_OP_REG   = 3'd2,
        NET_OP_PC    = 3'd3,
        NET_OP_BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic              yumi;
        logic              byte_not_word;
        logic [DATA_W-1:0] write_data;
    } mem_in_s;

    typedef struct packed {
        logic [ID_W-1:0]   net_id;
        net_op_e           net_op;
        logic [IDX_W-1:0]  net_addr;
        logic [DATA_W-1:0] net_data;
    } net_packet_s;

endpackage

interface core_boot_sequencer_if;

    logic [core_boot_sequencer_pkg::SEL_W-1:0]  img_sel_o;
    logic [core_boot_sequencer_pkg::IDX_W-1:0]  img_addr_o;
    logic [core_boot_sequencer_pkg::IMG_W-1:0]  img_data_i;
    core_boot_sequencer_pkg::mem_in_s           ldr_mem_o;
    logic [core_boot_sequencer_pkg::DATA_W-1:0] ldr_mem_addr_o;
    logic                                       mem_ready_i;
    core_boot_sequencer_pkg::net_packet_s       net_packet_o;

    modport master (
        output img_sel_o,
        output img_addr_o,
        input  img_data_i,
        output ldr_mem_o,
        output ldr_mem_addr_o,
        input  mem_ready_i,
        output net_packet_o
    );

    modport slave (
        input  img_sel_o,
        input  img_addr_o,
        output img_data_i,
        input  ldr_mem_o,
        input  ldr_mem_addr_o,
        output mem_ready_i,
        input  net_packet_o
    );

endinterface

// File: rtl/core_boot_sequencer.sv
// Boot sequencer: loads data_mem from the image, then streams INSTR/REG/BAR/PC packets
// into the core, holding the core in reset until its data memory is populated.
module core_boot_sequencer
    import core_boot_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WORDS  = 1024,
    parameter int unsigned INSTR_WORDS = 1024,
    parameter int unsigned REG_COUNT   = 64,
    parameter logic [9:0]  CORE_ID     = 10'd1,
    parameter logic [9:0]  BAR_ADDR    = 10'd24,
    parameter logic [31:0] BAR_MASK    = 32'h2,
    parameter logic [31:0] START_PC    = 32'h0
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  start_i,
    core_boot_sequencer_if.master bus,
    output logic                  dmem_sel_o,
    output logic                  core_n_reset_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_WORDS - 1);
    localparam logic [IDX_W-1:0] INSTR_LAST = IDX_W'(INSTR_WORDS - 1);
    localparam logic [IDX_W-1:0] REG_LAST   = IDX_W'(REG_COUNT - 1);

    localparam net_packet_s NULL_PKT = '{
        net_id:   CORE_ID,
        net_op:   NET_OP_NULL,
        net_addr: '0,
        net_data: '0
    };

    typedef enum logic [3:0] {
        S_IDLE,
        S_D_FETCH,
        S_D_LATCH,
        S_D_WRITE,
        S_D_DRAIN,
        S_I_STREAM,
        S_R_STREAM,
        S_BAR,
        S_PC,
        S_DONE
    } state_e;

    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [SEL_W-1:0]   r_img_sel;
    mem_in_s            r_mem;
    logic [DATA_W-1:0]  r_mem_addr;
    logic               r_dmem_sel;
    logic               r_core_n_reset;
    logic               r_busy;
    logic               r_done;
    net_packet_s        r_pkt;
    // Tag of the image word arriving on img_data_i this cycle (address issued last cycle).
    logic               r_dat_vld;
    logic               r_dat_reg;
    logic [IDX_W-1:0]   r_dat_addr;

    state_e             w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [SEL_W-1:0]   w_img_sel_nxt;
    mem_in_s            w_mem_nxt;
    logic [DATA_W-1:0]  w_mem_addr_nxt;
    logic               w_dmem_sel_nxt;
    logic               w_core_n_reset_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    net_packet_s        w_pkt_nxt;
    logic               w_streaming;
    logic               w_unused_img;

    assign w_streaming  = (r_state == S_I_STREAM) || (r_state == S_R_STREAM);
    assign w_unused_img = ^bus.img_data_i[IMG_W-1:38];

    // State and registered-output update.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_img_sel      <= '0;
            r_mem          <= '0;
            r_mem_addr     <= '0;
            r_dmem_sel     <= 1'b0;
            r_core_n_reset <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pkt          <= NULL_PKT;
            r_dat_vld      <= 1'b0;
            r_dat_reg      <= 1'b0;
            r_dat_addr     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_img_sel      <= w_img_sel_nxt;
            r_mem          <= w_mem_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_dmem_sel     <= w_dmem_sel_nxt;
            r_core_n_reset <= w_core_n_reset_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_pkt          <= w_pkt_nxt;
            r_dat_vld      <= w_streaming;
            r_dat_reg      <= (r_state == S_R_STREAM);
            r_dat_addr     <= r_idx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_img_sel_nxt      = r_img_sel;
        w_mem_nxt          = r_mem;
        w_mem_addr_nxt     = r_mem_addr;
        w_dmem_sel_nxt     = r_dmem_sel;
        w_core_n_reset_nxt = r_core_n_reset;
        w_busy_nxt         = r_busy;
        w_done_nxt         = r_done;
        w_pkt_nxt          = NULL_PKT;

        // Two-cycle stream pipeline: the word fetched last cycle becomes next cycle's packet.
        if (r_dat_vld) begin
            if (r_dat_reg) begin
                w_pkt_nxt.net_op   = NET_OP_REG;
                w_pkt_nxt.net_addr = IDX_W'(bus.img_data_i[37:32]);
                w_pkt_nxt.net_data = bus.img_data_i[31:0];
            end else begin
                w_pkt_nxt.net_op   = NET_OP_INSTR;
                w_pkt_nxt.net_addr = r_dat_addr;
                w_pkt_nxt.net_data = {16'b0, bus.img_data_i[15:0]};
            end
        end

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_state_nxt        = S_D_FETCH;
                    w_idx_nxt          = '0;
                    w_img_sel_nxt      = 2'd0;
                    w_busy_nxt         = 1'b1;
                    w_done_nxt         = 1'b0;
                    w_core_n_reset_nxt = 1'b0;
                    w_dmem_sel_nxt     = 1'b0;
                end
            end
            S_D_FETCH: begin
                w_state_nxt = S_D_LATCH;
            end
            S_D_LATCH: begin
                w_mem_nxt = '{
                    valid:         1'b1,
                    wen:           1'b1,
                    yumi:          1'b1,
                    byte_not_word: 1'b0,
                    write_data:    bus.img_data_i[31:0]
                };
                w_mem_addr_nxt = DATA_W'({r_idx, 2'b00});
                w_state_nxt    = S_D_WRITE;
            end
            S_D_WRITE: begin
                // Request stays untouched until data_mem takes it.
                if (bus.mem_ready_i) begin
                    w_mem_nxt.valid = 1'b0;
                    w_mem_nxt.wen   = 1'b0;
                    w_mem_nxt.yumi  = 1'b0;
                    if (r_idx == DATA_LAST) begin
                        w_state_nxt = S_D_DRAIN;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = S_D_FETCH;
                    end
                end
            end
            S_D_DRAIN: begin
                w_core_n_reset_nxt = 1'b1;
                w_idx_nxt          = '0;
                w_img_sel_nxt      = 2'd1;
                w_state_nxt        = S_I_STREAM;
            end
            S_I_STREAM: begin
                if (r_idx == INSTR_LAST) begin
                    w_idx_nxt     = '0;
                    w_img_sel_nxt = 2'd2;
                    w_state_nxt   = S_R_STREAM;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_R_STREAM: begin
                if (r_idx == REG_LAST) begin
                    w_state_nxt = S_BAR;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_BAR: begin
                if (!r_dat_vld) begin
                    w_pkt_nxt.net_op   = NET_OP_BAR;
                    w_pkt_nxt.net_addr = BAR_ADDR;
                    w_pkt_nxt.net_data = BAR_MASK;
                    w_state_nxt        = S_PC;
                end
            end
            S_PC: begin
                w_pkt_nxt.net_op   = NET_OP_PC;
                w_pkt_nxt.net_addr = '0;
                w_pkt_nxt.net_data = START_PC;
                w_busy_nxt         = 1'b0;
                w_done_nxt         = 1'b1;
                w_dmem_sel_nxt     = 1'b1;
                w_state_nxt        = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.img_sel_o      = r_img_sel;
    assign bus.img_addr_o     = r_idx;
    assign bus.ldr_mem_o      = r_mem;
    assign bus.ldr_mem_addr_o = r_mem_addr;
    assign bus.net_packet_o   = r_pkt;
    assign dmem_sel_o         = r_dmem_sel;
    assign core_n_reset_o     = r_core_n_reset;
    assign busy_o             = r_busy;
    assign done_o             = r_done;

endmodule
